// File: rtl/ptt_sequencer_pkg.sv
// Shared types for the RX/TX sequencer: FSM states, band identity, output bundle.
// Latency: n/a (types and a pure decode function only).
// Backpressure: n/a.
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_LNA_OFF,
    ST_TX_ANT,
    ST_TX_ON,
    ST_RX_PA_OFF,
    ST_RX_ANT
  } state_t;

  typedef enum logic [1:0] {
    BAND_NONE,
    BAND_B144,
    BAND_B430
  } band_t;

  // Registered output bundle, one bit per driver line.
  typedef struct packed {
    logic lna144;
    logic lna430;
    logic a144;
    logic a430;
    logic pa144;
    logic pa430;
    logic tx_ready;
    logic busy;
    logic band_err;
  } outs_t;

  localparam logic [2:0] BAND144_DEFAULT = 3'b110;
  localparam logic [2:0] BAND430_DEFAULT = 3'b101;

  function automatic band_t band_decode(input logic [2:0] code,
                                        input logic [2:0] c144,
                                        input logic [2:0] c430);
    band_t b;
    b = BAND_NONE;
    if (code == c144)      b = BAND_B144;
    else if (code == c430) b = BAND_B430;
    return b;
  endfunction

endpackage

// File: rtl/ptt_sequencer_debounce.sv
// PTT conditioning: 2-FF synchronizer on the raw active-low line, then a level debouncer.
// Latency: raw edge to ptt_act change is DEB_CYC+2 cycles.
// Backpressure: none; free-running level filter.
// Ports: clk, reset (async active-low), ptt (raw, active-low), ptt_act (debounced, active-high).
module ptt_debounce #(
  parameter int unsigned DEB_CYC = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic ptt,
  output logic ptt_act
);

  localparam int unsigned DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic          ptt_s1;
  logic          ptt_s2;
  logic [DW-1:0] cnt;
  logic          mismatch;

  // Synchronizer resets to the idle (released) level of the raw line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptt_s1 <= 1'b1;
      ptt_s2 <= 1'b1;
    end else begin
      ptt_s1 <= ptt;
      ptt_s2 <= ptt_s1;
    end
  end

  assign mismatch = (~ptt_s2) != ptt_act;

  // Flip only after DEB_CYC consecutive disagreeing cycles; one agreeing cycle restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      ptt_act <= 1'b0;
    end else if (mismatch) begin
      if (cnt == DW'(DEB_CYC - 1)) begin
        cnt     <= '0;
        ptt_act <= ~ptt_act;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/ptt_sequencer.sv
// Timed RX/TX switching for the 144/430 MHz front end: LNA off -> relay -> PA on, and back.
// Latency: outputs registered from next state; each sequencing step dwells STEP_CYC cycles.
// Backpressure: none; release aborts a key-up in progress, re-press waits for IDLE.
// Ports: clk, reset (async active-low), ptt (raw, active-low), band[2:0];
//        lna/a/pa per band, tx_ready, busy, band_err (all registered, reset 0).
module ptt_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned DEB_CYC  = 50000,
  parameter int unsigned STEP_CYC = 500000,
  parameter logic [2:0]  BAND144  = BAND144_DEFAULT,
  parameter logic [2:0]  BAND430  = BAND430_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ptt,
  input  logic [2:0] band,
  output logic       lna144,
  output logic       lna430,
  output logic       a144,
  output logic       a430,
  output logic       pa144,
  output logic       pa430,
  output logic       tx_ready,
  output logic       busy,
  output logic       band_err
);

  localparam int unsigned SW = $clog2(STEP_CYC + 1);

  logic          ptt_act;
  band_t         live_band;
  band_t         cur_band;
  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] step_cnt;
  logic          step_done;
  outs_t         out_nxt;
  outs_t         out_q;

  ptt_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_deb (
    .clk     (clk),
    .reset   (reset),
    .ptt     (ptt),
    .ptt_act (ptt_act)
  );

  assign live_band = band_decode(band, BAND144, BAND430);
  assign step_done = (step_cnt == '0);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:       if (ptt_act && live_band != BAND_NONE) state_nxt = ST_TX_LNA_OFF;
      ST_TX_LNA_OFF: begin
        if (!ptt_act)       state_nxt = ST_IDLE;
        else if (step_done) state_nxt = ST_TX_ANT;
      end
      ST_TX_ANT: begin
        // Relay already moved: release must back out through PA-off/relay-off.
        if (!ptt_act)       state_nxt = ST_RX_PA_OFF;
        else if (step_done) state_nxt = ST_TX_ON;
      end
      ST_TX_ON:      if (!ptt_act) state_nxt = ST_RX_PA_OFF;
      ST_RX_PA_OFF:  if (step_done) state_nxt = ST_RX_ANT;
      ST_RX_ANT:     if (step_done) state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  // Band is frozen for the whole TX excursion so a relay never follows a live band change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                           cur_band <= BAND_NONE;
    else if (state == ST_IDLE && state_nxt == ST_TX_LNA_OFF) cur_band <= live_band;
  end

  // Step timer: reloads on every state change, counts down to zero and holds there.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  step_cnt <= '0;
    else if (state_nxt != state) step_cnt <= SW'(STEP_CYC - 1);
    else if (!step_done)         step_cnt <= step_cnt - 1'b1;
  end

  // Output decode from the next state, registered below so outputs change with the state.
  always_comb begin
    out_nxt      = '0;
    out_nxt.busy = (state_nxt != ST_IDLE);
    case (state_nxt)
      ST_IDLE: begin
        out_nxt.lna144   = (live_band == BAND_B144);
        out_nxt.lna430   = (live_band == BAND_B430);
        out_nxt.band_err = ptt_act && (live_band == BAND_NONE);
      end
      ST_TX_ANT, ST_RX_PA_OFF: begin
        out_nxt.a144 = (cur_band == BAND_B144);
        out_nxt.a430 = (cur_band == BAND_B430);
      end
      ST_TX_ON: begin
        out_nxt.a144     = (cur_band == BAND_B144);
        out_nxt.a430     = (cur_band == BAND_B430);
        out_nxt.pa144    = (cur_band == BAND_B144);
        out_nxt.pa430    = (cur_band == BAND_B430);
        out_nxt.tx_ready = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) out_q <= '0;
    else        out_q <= out_nxt;
  end

  assign lna144   = out_q.lna144;
  assign lna430   = out_q.lna430;
  assign a144     = out_q.a144;
  assign a430     = out_q.a430;
  assign pa144    = out_q.pa144;
  assign pa430    = out_q.pa430;
  assign tx_ready = out_q.tx_ready;
  assign busy     = out_q.busy;
  assign band_err = out_q.band_err;

endmodule

// File: doc/ptt_sequencer.md
# ptt_sequencer

Timed RX/TX switching controller for the two-band (144/430 MHz) front end. Debounces the active-low PTT line, latches the selected band, and steps the LNA, antenna relay and PA enables through a fixed-delay make/break order so that no relay is switched hot and no PA keys into the LNA. It sits between the transceiver's PTT/band-data pins and the relay/bias drivers, replacing direct combinational muxing with a sequenced state machine.

## Interface
- DEB_CYC, 16'd50000: debounce qualification length in clk cycles (≥1).
- STEP_CYC, 24'd500000: dwell per sequencing step in clk cycles (≥1).
- BAND144, 3'b110: band code selecting 144 MHz.
- BAND430, 3'b101: band code selecting 430 MHz.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- ptt  in  1  raw PTT from radio, active-low (0 = transmit request), asynchronous.
- band  in  3  band data from radio, quasi-static.
- lna144 / lna430  out  1  LNA enable per band, active-high.
- a144 / a430  out  1  antenna relay per band, 1 = TX position.
- pa144 / pa430  out  1  PA enable per band, active-high.
- tx_ready  out  1  high while PA is enabled (radio may key RF).
- busy  out  1  high in any state other than IDLE.
- band_err  out  1  high while PTT is active with an undecodable band.

## Operation
- PTT path: 2-FF synchronizer, then debouncer. Debounced level ptt_act (active-high) changes only after the synchronized input differs from it for DEB_CYC consecutive cycles. Any mismatch-free cycle clears the counter.
- Band decode: BAND144 → 144, BAND430 → 430, anything else → NONE. Band is latched into cur_band on the IDLE→TX_LNA_OFF transition and held until IDLE is re-entered.
- States: IDLE, TX_LNA_OFF, TX_ANT, TX_ON, RX_PA_OFF, RX_ANT.
- IDLE: lna of the live decoded band = 1, other outputs 0. Band changes take effect on the LNA the next cycle. If ptt_act=1 and band valid → TX_LNA_OFF. If ptt_act=1 and band NONE → stay, band_err=1.
- TX_LNA_OFF: all 0. After STEP_CYC cycles → TX_ANT.
- TX_ANT: a(cur_band)=1. After STEP_CYC → TX_ON.
- TX_ON: a=1, pa(cur_band)=1, tx_ready=1. Held until ptt_act=0 → RX_PA_OFF.
- RX_PA_OFF: a=1, pa=0. After STEP_CYC → RX_ANT.
- RX_ANT: all 0. After STEP_CYC → IDLE.
- Abort on release: TX_LNA_OFF with ptt_act=0 → IDLE. TX_ANT with ptt_act=0 → RX_PA_OFF, with the step counter reloaded.
- Re-press during RX_PA_OFF/RX_ANT is ignored; the release sequence always completes. A still-active ptt_act is acted on from IDLE.
- Band input changes outside IDLE are ignored.
- Only the latched band's a/pa are ever asserted. Outputs of the other band stay 0 in all non-IDLE states.

## Timing
- All outputs are registered Moore outputs, decoded from the next state. Their reset value is 0, including lna. The first cycle after reset release is IDLE, and lna goes high one cycle later.
- Raw ptt edge → ptt_act change: DEB_CYC+2 cycles.
- ptt_act rise at cycle N:
  - lna low at N+1.
  - a high at N+1+STEP_CYC.
  - pa and tx_ready high at N+1+2·STEP_CYC.
- ptt_act fall at cycle M in TX_ON:
  - pa and tx_ready low at M+1.
  - a low at M+1+STEP_CYC.
  - lna high at M+1+2·STEP_CYC.
- Step counter: width $clog2(STEP_CYC+1). It loads on every state entry and transitions on reaching terminal count. No wrap.
- Asynchronous reset mid-sequence: all outputs 0 immediately, state IDLE, debouncer and synchronizer cleared to inactive.

## Structure
- Package seq_pkg: state enum, band enum (NONE/B144/B430), default band codes.
- Sub-module ptt_debounce (synchronizer + counter, parameter DEB_CYC). Instantiate it once.
- Top level: band latch, step counter, FSM, output register.

## Test plan
Run with DEB_CYC=4, STEP_CYC=3.
- Reset release, band=110, ptt=1: all outputs 0 during reset, then lna144=1, busy=0.
- band=110, ptt→0 held:
  - lna144 falls 7 cycles after the edge.
  - a144 rises 3 cycles later.
  - pa144 and tx_ready rise 3 cycles after that.
  - All 430 outputs stay 0.
- From TX_ON, ptt→1:
  - pa144 falls after DEB_CYC+3 cycles.
  - a144 falls 3 cycles after pa144.
  - lna144 rises 3 cycles after a144.
- ptt glitch low for 3 cycles: no state change, busy stays 0.
- band=000, ptt=0: band_err=1, all a/pa 0, lna 0.
- Remaining cases:
  - Band switched to 101 during TX_ON: outputs unchanged. After return to IDLE, lna430=1.
  - ptt released during TX_ANT: a144 drops 3 cycles after entering RX_PA_OFF.
  - Reset asserted in TX_ON: all outputs 0 within the same cycle.
